// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and helpers for the round-robin bit-scan arbiter.
//   arb_state_e : arbitration FSM states (ARB = free arbitration,
//                 LOCK = grant pinned to one channel until its last beat)
//   calc_id_w() : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package rr_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int calc_id_w(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lsb_onehot.sv
// -----------------------------------------------------------------------------
// lsb_onehot
// Isolates the lowest-index set bit of a vector as a one-hot vector.
// An all-zero input gives an all-zero output.
//   i_vec    : input request vector
//   o_onehot : one-hot lowest set bit of i_vec
// -----------------------------------------------------------------------------
module lsb_onehot #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_onehot
);

    // Subtracting one flips the lowest set bit and every zero below it, so
    // the AND with the inverted difference keeps only that lowest set bit.
    assign o_onehot = i_vec & ~(i_vec - WIDTH'(1));

endmodule

// File: rtl/rr_bitscan_arbiter.sv
// -----------------------------------------------------------------------------
// rr_bitscan_arbiter
// Round-robin arbiter that merges NUM_CH valid/ready streams into one
// registered output stage. The winner is the first requesting channel at or
// above the priority pointer, wrapping to channel 0. With PKT_LOCK=1 the grant
// is held on one channel from its first beat until its last beat.
//   clk       : rising-edge clock
//   rst_b     : asynchronous active-low reset
//   in_valid  : per-channel request valid
//   in_data   : packed payloads, channel i at [i*DATA_W +: DATA_W]
//   in_last   : per-channel last-beat flag
//   in_ready  : per-channel accept, at most one bit set
//   out_valid : registered output valid
//   out_data  : registered payload
//   out_id    : source channel of out_data
//   out_last  : registered last flag
//   out_ready : downstream accept
// -----------------------------------------------------------------------------
module rr_bitscan_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int PKT_LOCK = 1
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_last,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [calc_id_w(NUM_CH)-1:0] out_id,
    output logic                       out_last,
    input  logic                       out_ready
);

    localparam int ID_W = calc_id_w(NUM_CH);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ID_W-1:0]     r_lock_id;
    logic [ID_W-1:0]     w_lock_id_nxt;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_id;
    logic                r_out_last;

    logic                w_load_en;
    logic [NUM_CH-1:0]   w_mask;
    logic [NUM_CH-1:0]   w_masked_req;
    logic [NUM_CH-1:0]   w_masked_oh;
    logic [NUM_CH-1:0]   w_full_oh;
    logic [NUM_CH-1:0]   w_arb_gnt;
    logic [NUM_CH-1:0]   w_gnt;
    logic                w_accept;
    logic [ID_W-1:0]     w_win_id;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_win_last;

    // The output register can take a new beat when empty or being drained.
    assign w_load_en = !r_out_valid | out_ready;

    // Channels at or above the pointer; r_ptr never exceeds NUM_CH-1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
    end

    assign w_masked_req = in_valid & w_mask;

    lsb_onehot #(.WIDTH(NUM_CH)) u_masked_scan (
        .i_vec    (w_masked_req),
        .o_onehot (w_masked_oh)
    );

    lsb_onehot #(.WIDTH(NUM_CH)) u_full_scan (
        .i_vec    (in_valid),
        .o_onehot (w_full_oh)
    );

    // Fall back to the unmasked scan when nothing is requesting at or above
    // the pointer: that is the wrap-around to the low channels.
    assign w_arb_gnt = (|w_masked_req) ? w_masked_oh : w_full_oh;

    // FSM output logic: in LOCK the grant is pinned even if that channel is
    // idle, so the packet can never be interleaved with another channel.
    always_comb begin
        w_gnt = '0;
        unique case (r_state)
            ARB:  w_gnt = w_arb_gnt;
            LOCK: w_gnt = NUM_CH'(1) << r_lock_id;
            default: w_gnt = '0;
        endcase
    end

    assign in_ready = w_gnt & {NUM_CH{w_load_en}};
    assign w_accept = |(in_valid & in_ready);

    // Select the granted channel's id, payload and last flag.
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, otherwise paths that skip an assignment infer a latch.
    always_comb begin
        w_win_id   = '0;
        w_win_data = '0;
        w_win_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_win_id   = ID_W'(i);
                w_win_data = in_data[i*DATA_W +: DATA_W];
                w_win_last = in_last[i];
            end
        end
    end

    // Pointer advances past the winner at packet end (every beat without
    // packet locking); explicit wrap keeps it below NUM_CH for any NUM_CH.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_accept && (w_win_last || (PKT_LOCK == 0))) begin
            w_ptr_nxt = (w_win_id == ID_W'(NUM_CH - 1)) ? '0 : w_win_id + ID_W'(1);
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        unique case (r_state)
            ARB: begin
                if ((PKT_LOCK != 0) && w_accept && !w_win_last) begin
                    w_state_nxt   = LOCK;
                    w_lock_id_nxt = w_win_id;
                end
            end
            LOCK: begin
                if (w_accept && w_win_last) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ARB;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // Pointer and single-entry output register.
    // NOTE: the output payload is reset as well as the valid bit, so the
    // visible outputs are all zero while reset is held.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_load_en) begin
                r_out_valid <= w_accept;
            end
            if (w_accept) begin
                r_out_data <= w_win_data;
                r_out_id   <= w_win_id;
                r_out_last <= w_win_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_bitscan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_bitscan_arbiter
// Three arbiter instances (4 ch no lock, 4 ch packet lock, 5 ch packet lock)
// driven by directed scenarios and then random traffic. A behavioural model
// (circular scan from the pointer, lock flag, one output slot) is compared
// with every instance on every falling edge.
// -----------------------------------------------------------------------------
module tb_rr_bitscan_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;

    // Instance A: NUM_CH=4, PKT_LOCK=0
    logic [3:0]   a_valid, a_last, a_rdy;
    logic [127:0] a_data;
    logic         a_ordy, a_ov, a_ol;
    logic [31:0]  a_od;
    logic [1:0]   a_oid;
    // Instance B: NUM_CH=4, PKT_LOCK=1
    logic [3:0]   b_valid, b_last, b_rdy;
    logic [127:0] b_data;
    logic         b_ordy, b_ov, b_ol;
    logic [31:0]  b_od;
    logic [1:0]   b_oid;
    // Instance C: NUM_CH=5, PKT_LOCK=1
    logic [4:0]   c_valid, c_last, c_rdy;
    logic [159:0] c_data;
    logic         c_ordy, c_ov, c_ol;
    logic [31:0]  c_od;
    logic [2:0]   c_oid;

    rr_bitscan_arbiter #(.NUM_CH(4), .DATA_W(32), .PKT_LOCK(0)) u_dut_a (
        .clk(clk), .rst_b(rst_b), .in_valid(a_valid), .in_data(a_data),
        .in_last(a_last), .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od),
        .out_id(a_oid), .out_last(a_ol), .out_ready(a_ordy));

    rr_bitscan_arbiter #(.NUM_CH(4), .DATA_W(32), .PKT_LOCK(1)) u_dut_b (
        .clk(clk), .rst_b(rst_b), .in_valid(b_valid), .in_data(b_data),
        .in_last(b_last), .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od),
        .out_id(b_oid), .out_last(b_ol), .out_ready(b_ordy));

    rr_bitscan_arbiter #(.NUM_CH(5), .DATA_W(32), .PKT_LOCK(1)) u_dut_c (
        .clk(clk), .rst_b(rst_b), .in_valid(c_valid), .in_data(c_data),
        .in_last(c_last), .in_ready(c_rdy), .out_valid(c_ov), .out_data(c_od),
        .out_id(c_oid), .out_last(c_ol), .out_ready(c_ordy));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          ptr;
        bit          locked;
        int          lock_id;
        bit          ov;
        logic [31:0] od;
        int          oid;
        bit          ol;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ptr = 0; m.locked = 1'b0; m.lock_id = 0;
        m.ov = 1'b0; m.od = '0; m.oid = 0; m.ol = 1'b0;
        return m;
    endfunction

    // Which channel is offered a grant this cycle: none while the output is
    // stalled, the locked channel during a packet, else the first requester
    // walking upward from the pointer around the ring.
    function automatic logic [7:0] exp_ready(mdl_t m, int n, logic [7:0] v, bit ordy);
        if (m.ov && !ordy) return 8'h00;
        if (m.locked) return 8'(1) << m.lock_id;
        for (int k = 0; k < n; k++) begin
            int ch;
            ch = (m.ptr + k) % n;
            if (v[ch]) return 8'(1) << ch;
        end
        return 8'h00;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int n, bit plock, logic [7:0] v,
                                      logic [7:0][31:0] d, logic [7:0] l, bit ordy);
        mdl_t nm;
        logic [7:0] r;
        int c;
        nm = m;
        r  = exp_ready(m, n, v, ordy);
        c  = -1;
        for (int k = 0; k < n; k++) if (r[k] && v[k]) c = k;
        if (!m.ov || ordy) nm.ov = 1'b0;
        if (c >= 0) begin
            nm.ov  = 1'b1;
            nm.od  = d[c];
            nm.oid = c;
            nm.ol  = l[c];
            if (plock && !m.locked && !l[c]) begin
                nm.locked  = 1'b1;
                nm.lock_id = c;
            end else if (m.locked && l[c]) begin
                nm.locked = 1'b0;
            end
            if (l[c] || !plock) nm.ptr = (c + 1) % n;
        end
        return nm;
    endfunction

    task automatic cmp_step(input string tag, input mdl_t m_in, input int n, input bit plock,
                            input logic [7:0] v, input logic [7:0][31:0] d, input logic [7:0] l,
                            input bit ordy, input logic [7:0] rdy, input logic ov,
                            input logic [31:0] od, input int oid, input logic ol,
                            output mdl_t m_out);
        mdl_t m;
        m = rst_b ? m_in : mdl_reset();
        check({tag, ".in_ready"}, 64'(rdy), 64'(exp_ready(m, n, v, ordy)));
        check({tag, ".out_valid"}, 64'(ov), 64'(m.ov));
        if (m.ov || !rst_b) begin
            check({tag, ".out_data"}, 64'(od), 64'(m.od));
            check({tag, ".out_id"}, 64'(oid), 64'(m.oid));
            check({tag, ".out_last"}, 64'(ol), 64'(m.ol));
        end
        m_out = rst_b ? mdl_step(m, n, plock, v, d, l, ordy) : m;
    endtask

    // Compare process: inputs only change just after a rising edge, so the
    // falling edge sees settled outputs and the inputs the next edge will use.
    always @(negedge clk) begin : cmp_blk
        logic [7:0][31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i] = a_data[i*32 +: 32];
        cmp_step("A", ma, 4, 1'b0, 8'(a_valid), d, 8'(a_last), a_ordy, 8'(a_rdy),
                 a_ov, a_od, int'(a_oid), a_ol, ma);
        d = '0;
        for (int i = 0; i < 4; i++) d[i] = b_data[i*32 +: 32];
        cmp_step("B", mb, 4, 1'b1, 8'(b_valid), d, 8'(b_last), b_ordy, 8'(b_rdy),
                 b_ov, b_od, int'(b_oid), b_ol, mb);
        d = '0;
        for (int i = 0; i < 5; i++) d[i] = c_data[i*32 +: 32];
        cmp_step("C", mc, 5, 1'b1, 8'(c_valid), d, 8'(c_last), c_ordy, 8'(c_rdy),
                 c_ov, c_od, int'(c_oid), c_ol, mc);
    end

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        rst_b = 1'b0;
        a_valid = '0; a_last = '0; a_data = '0; a_ordy = 1'b1;
        b_valid = 4'b0110; b_last = '0; b_data = '0; b_ordy = 1'b1;
        c_valid = '0; c_last = '0; c_data = '0; c_ordy = 1'b1;

        // Reset: outputs zero, in_ready still arbitrates from ptr=0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.b_rdy", 64'(b_rdy), 64'h2);
        check("rst.b_out", 64'({b_ov, b_od, b_oid, b_ol}), 64'h0);
        check("rst.a_out", 64'({a_ov, a_od, a_oid, a_ol}), 64'h0);
        step_in();
        rst_b = 1'b1;
        b_valid = '0;

        // Fairness on A: all valid, one beat per cycle in rotation.
        a_valid = 4'hF;
        for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int j = 0; j < 7; j++) begin
            step_in();
            if (j == 6) a_valid = '0;
            @(negedge clk);
            check("fair.id", 64'(a_oid), 64'(j % 4));
            check("fair.valid", 64'(a_ov), 64'h1);
        end

        // Wrap with sparse mask from ptr=3.
        step_in();
        a_valid = 4'b0101;
        step_in();
        @(negedge clk);
        check("wrap.first_id", 64'(a_oid), 64'h0);
        check("wrap.first_data", 64'(a_od), 64'hA0);
        step_in();
        a_valid = '0;
        @(negedge clk);
        check("wrap.second_id", 64'(a_oid), 64'h2);

        // Packet lock on B: ch1 three beats while ch2 waits, with a one-cycle
        // gap in ch1 mid-packet.
        step_in();
        b_valid = 4'b0110; b_last = 4'b0100;
        b_data[32 +: 32] = 32'h11; b_data[64 +: 32] = 32'h22;
        step_in();
        b_data[32 +: 32] = 32'h12; b_valid = 4'b0100;
        @(negedge clk);
        check("lock.b1_id", 64'(b_oid), 64'h1);
        check("lock.b1_data", 64'(b_od), 64'h11);
        check("lock.b1_last", 64'(b_ol), 64'h0);
        check("lock.gap_rdy", 64'(b_rdy), 64'h2);
        step_in();
        b_valid = 4'b0110;
        @(negedge clk);
        check("lock.gap_valid", 64'(b_ov), 64'h0);
        check("lock.gap_rdy2", 64'(b_rdy), 64'h2);
        step_in();
        b_data[32 +: 32] = 32'h13; b_last = 4'b0110;
        @(negedge clk);
        check("lock.b2_id", 64'(b_oid), 64'h1);
        check("lock.b2_data", 64'(b_od), 64'h12);
        step_in();
        b_data[32 +: 32] = 32'h1F;
        @(negedge clk);
        check("lock.b3_id", 64'(b_oid), 64'h1);
        check("lock.b3_data", 64'(b_od), 64'h13);
        check("lock.b3_last", 64'(b_ol), 64'h1);
        step_in();
        b_valid = '0;
        @(negedge clk);
        check("lock.after_id", 64'(b_oid), 64'h2);
        check("lock.after_data", 64'(b_od), 64'h22);

        // Backpressure on B.
        step_in();
        b_valid = 4'b0001; b_last = 4'b0001; b_data[0 +: 32] = 32'hB0;
        step_in();
        b_ordy = 1'b0; b_data[0 +: 32] = 32'hB1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("bp.data", 64'(b_od), 64'hB0);
            check("bp.valid", 64'(b_ov), 64'h1);
            check("bp.rdy", 64'(b_rdy), 64'h0);
            step_in();
        end
        b_ordy = 1'b1;
        @(negedge clk);
        check("bp.release_rdy", 64'(b_rdy), 64'h1);
        step_in();
        b_valid = '0;
        @(negedge clk);
        check("bp.next_data", 64'(b_od), 64'hB1);

        // Reset in the middle of a ch2 packet on B.
        step_in();
        b_valid = 4'b0100; b_last = 4'b0000; b_data[64 +: 32] = 32'hC1;
        step_in();
        b_data[64 +: 32] = 32'hC2;
        rst_b = 1'b0;
        @(negedge clk);
        check("rstmid.out", 64'({b_ov, b_od, b_oid, b_ol}), 64'h0);
        check("rstmid.rdy", 64'(b_rdy), 64'h4);
        step_in();
        rst_b = 1'b1;
        b_valid = 4'b1100; b_last = 4'b0100; b_data[64 +: 32] = 32'hC3;
        @(negedge clk);
        check("rstmid.release_rdy", 64'(b_rdy), 64'h4);
        step_in();
        b_valid = '0; b_last = '0;
        @(negedge clk);
        check("rstmid.id", 64'(b_oid), 64'h2);
        check("rstmid.data", 64'(b_od), 64'hC3);

        // Five channels: ch4 alone repeatedly, pointer wraps 4 -> 0.
        step_in();
        c_valid = 5'b10000; c_last = 5'b11111;
        c_data[0 +: 32] = 32'hD0; c_data[128 +: 32] = 32'hD4;
        for (int j = 0; j < 5; j++) begin
            step_in();
            if (j == 4) c_valid = 5'b10001;
            @(negedge clk);
            check("n5.id4", 64'(c_oid), 64'h4);
        end
        step_in();
        @(negedge clk);
        check("n5.wrap_id0", 64'(c_oid), 64'h0);
        step_in();
        @(negedge clk);
        check("n5.then_id4", 64'(c_oid), 64'h4);
        step_in();
        c_valid = '0;
        @(negedge clk);
        check("n5.again_id0", 64'(c_oid), 64'h0);

        // Random traffic, occasional reset pulses.
        repeat (3000) begin
            step_in();
            rst_b  = ($urandom_range(0, 399) != 0);
            a_valid = 4'($urandom);
            a_last  = 4'($urandom);
            a_ordy  = ($urandom_range(0, 3) != 0);
            b_valid = 4'($urandom);
            b_last  = 4'($urandom & $urandom);
            b_ordy  = ($urandom_range(0, 3) != 0);
            c_valid = 5'($urandom);
            c_last  = 5'($urandom & $urandom);
            c_ordy  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                a_data[i*32 +: 32] = $urandom;
                b_data[i*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 5; i++) c_data[i*32 +: 32] = $urandom;
        end

        step_in();
        rst_b = 1'b1;
        a_valid = '0; b_valid = '0; c_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
